alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational `Alu` instance (4-bit `ALUControl`, 4-bit flags) between `NREQ` requesters in the reverb datapath, e.g. the echo/gain unit and the processor execute stage. Accepts one operation per grant using round-robin arbitration. Registers the operands, drives the ALU, captures result and flags, and returns them to the winning requester as a one-cycle response pulse.

## Interface
- `WIDTH`, 32, operand/result width; must match the `Alu` width parameter.
- `NREQ`, 2, number of requesters (2..8).
- `DIV_CYCLES`, 4, EXEC hold cycles for opcode 4'b0011; used only when `ALU_ARB_DIV_MULTICYCLE_EN` is defined; must be ≥1.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  request i pending; must be held until `req_ready[i]`.
- `req_op`  in  4*NREQ  per-requester ALUControl, slice [4i+3:4i].
- `req_a`  in  WIDTH*NREQ  per-requester op1.
- `req_b`  in  WIDTH*NREQ  per-requester op2.
- `req_ready`  out  NREQ  one-hot accept strobe; combinational from state, pointer and `req_valid`.
- `rsp_valid`  out  NREQ  one-hot, one-cycle response pulse to the granted requester.
- `rsp_result`  out  WIDTH  registered ALU result; valid while any `rsp_valid` bit is set.
- `rsp_flags`  out  4  registered ALU flags, passed through unmodified.
- `alu_ctrl`  out  4  to ALU `ALUControl`.
- `alu_op1`, `alu_op2`  out  WIDTH each  to ALU operands.
- `alu_result`  in  WIDTH  from ALU.
- `alu_flags`  in  4  from ALU.

## Operation
- States: IDLE, EXEC, RESP.
- Accept is allowed only in IDLE or RESP.
  - Pick the first asserted `req_valid` searching upward from `rr_ptr`, wrapping modulo NREQ.
  - Assert that requester's `req_ready` bit.
  - Latch op, a, b and the index.
  - `rr_ptr` ← index+1 (mod NREQ).
  - Go to EXEC.
- No request in IDLE or RESP: go to (or stay in) IDLE.
- EXEC:
  - `alu_*` are driven from the latched registers.
  - On the last EXEC cycle, sample `alu_result`/`alu_flags` into the `rsp_*` registers and go to RESP.
- RESP: `rsp_valid[idx]`=1 for exactly one cycle.
- Outside EXEC: `alu_ctrl`=4'b1000 (mov), `alu_op1`=`alu_op2`=0.
- Opcodes are not decoded except 4'b0011 when the macro is defined. Undefined codes 4'b1001–4'b1111 pass through; the response is whatever the ALU returns.
- Reset values:
  - state=IDLE, `rr_ptr`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_flags`=0.
  - `alu_ctrl`=4'b0000, `alu_op1`=`alu_op2`=0.

## Timing
- Accept at edge T → EXEC during cycle T+1 → `rsp_valid` high in cycle T+2 (2-cycle latency, non-div).
- A new accept in the RESP cycle gives back-to-back throughput of one operation per 2 cycles.
- Simultaneous requests: exactly one grant per accept cycle. A losing requester keeps `req_valid` high and wins the next accept cycle unless `rr_ptr` passes it; with NREQ=2 the requesters strictly alternate under continuous load.
- `rr_ptr` wraps from NREQ-1 to 0.
- Requester-side timing: the granted requester may deassert or change `req_valid` the cycle after `req_ready`. The same requester may re-request and be accepted in the RESP cycle of its own response if it is next in round-robin order.
- `rst` asserted in any state: the in-flight operation is discarded, no `rsp_valid` is produced, and outputs take reset values in the next cycle.
- `req_valid` deasserted before a grant has no effect; no request is remembered.

## Configuration
- `ALU_ARB_DIV_MULTICYCLE_EN` defined: an accepted 4'b0011 operation stays in EXEC for `DIV_CYCLES` cycles.
  - An internal down-counter is loaded at accept.
  - `alu_*` stay stable throughout.
  - Result is sampled on the final EXEC cycle; `rsp_valid` appears at T+1+`DIV_CYCLES`.
- Not defined: division takes 1 EXEC cycle like every other opcode; no counter is present.

## Test plan
- Single add: req0 op=4'b0000, a=7, b=2 → `req_ready`=2'b01 at T, `rsp_valid`=2'b01 at T+2, `rsp_result`=9.
- Contention after reset: req0 sub 7−2 and req1 shl 31<<5 both valid at T → req0 granted first, result 5 at T+2; req1 granted at T+2, result 992 at T+4.
- Fairness: both requesters held valid for 10 cycles → grants alternate 0,1,0,1,… and each requester gets one `rsp_valid` every 4 cycles.
- Division 10/2 (op 4'b0011) with macro defined, `DIV_CYCLES`=4 → `alu_ctrl`=4'b0011 for 4 cycles, `rsp_valid` at T+5, result 5. Without the macro → `rsp_valid` at T+2.
- Reset mid-EXEC: req0 and 0x1F/0x15, `rst` pulsed at T+1 → no `rsp_valid`, all outputs zero at T+2, next grant goes to requester 0.
- Idle drive: no requests for 5 cycles after reset exits → `alu_ctrl`=4'b1000 and operands 0 from the first cycle after reset, `req_ready`=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU; define ALU_ARB_DIV_MULTICYCLE_EN for multi-cycle divide
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [4*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [3:0]            rsp_flags,
  output logic [3:0]            alu_ctrl,
  output logic [WIDTH-1:0]      alu_op1,
  output logic [WIDTH-1:0]      alu_op2,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic [3:0]            alu_flags
);
  localparam int PW = $clog2(NREQ);
  localparam logic [3:0] MOV = 4'b1000;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, idx_q, idx_d, pick;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d, alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d;
  logic [3:0] rsp_flags_q, rsp_flags_d, alu_ctrl_q, alu_ctrl_d;
  logic found, accept, last;
  if (DIV_CYCLES < 1 || NREQ < 2 || NREQ > 8) begin : g_bad_param
    $error("alu_arbiter: parameter out of range");
  end
  // first pending requester at or above rr_ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        pick = PW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end
  assign accept = !rst && found && state_q != EXEC;
  assign req_ready = accept ? NREQ'(1) << pick : '0;
`ifdef ALU_ARB_DIV_MULTICYCLE_EN
  localparam int CW = $clog2(DIV_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign last = cnt_q == '0;
  // divide hold counter, loaded at accept and counted down through EXEC
  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = req_op[4*pick +: 4] == 4'b0011 ? CW'(DIV_CYCLES - 1) : '0;
    else if (state_q == EXEC && !last) cnt_d = cnt_q - 1'b1;
  end
  // divide counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`else
  assign last = 1'b1;
`endif
  // next state, operand latch into the ALU drive registers, response capture
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d = idx_q;
    alu_ctrl_d = MOV;
    alu_op1_d = '0;
    alu_op2_d = '0;
    rsp_valid_d = '0;
    rsp_result_d = rsp_result_q;
    rsp_flags_d = rsp_flags_q;
    if (accept) begin
      state_d = EXEC;
      idx_d = pick;
      rr_ptr_d = PW'((int'(pick) + 1) % NREQ);
      alu_ctrl_d = req_op[4*pick +: 4];
      alu_op1_d = req_a[WIDTH*pick +: WIDTH];
      alu_op2_d = req_b[WIDTH*pick +: WIDTH];
    end else if (state_q == EXEC && last) begin
      state_d = RESP;
      rsp_valid_d = NREQ'(1) << idx_q;
      rsp_result_d = alu_result;
      rsp_flags_d = alu_flags;
    end else if (state_q == EXEC) begin
      alu_ctrl_d = alu_ctrl_q;
      alu_op1_d = alu_op1_q;
      alu_op2_d = alu_op2_q;
    end else begin
      state_d = IDLE;
    end
  end
  // state and output registers; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      idx_q <= '0;
      rsp_valid_q <= '0;
      rsp_result_q <= '0;
      rsp_flags_q <= '0;
      alu_ctrl_q <= 4'b0000;
      alu_op1_q <= '0;
      alu_op2_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q <= rsp_flags_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_op1_q <= alu_op1_d;
      alu_op2_q <= alu_op2_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags = rsp_flags_q;
  assign alu_ctrl = alu_ctrl_q;
  assign alu_op1 = alu_op1_q;
  assign alu_op2 = alu_op2_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized requesters checked against a transaction-timeline reference model
module tb_alu_arbiter;
  localparam int W = 32, N = 3, DC = 4, NC = 1500;
`ifdef ALU_ARB_DIV_MULTICYCLE_EN
  localparam int DIV_LAT = DC + 1;
`else
  localparam int DIV_LAT = 2;
`endif
  logic clk = 1'b0, rst;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [4*N-1:0] req_op;
  logic [W*N-1:0] req_a, req_b;
  logic [W-1:0] rsp_result, alu_op1, alu_op2, alu_result;
  logic [3:0] rsp_flags, alu_ctrl, alu_flags;
  int errors = 0, checks = 0;
  logic [3:0] e_ctrl [NC+16];
  logic [W-1:0] e_o1 [NC+16], e_o2 [NC+16], e_res [NC+16];
  logic [3:0] e_fl [NC+16];
  logic [N-1:0] e_rv [NC+16];
  bit e_rst [NC+16];
  bit pend [N];
  logic [3:0] p_op [N];
  logic [W-1:0] p_a [N], p_b [N];
  logic [3:0] ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0011, 4'b1000, 4'b1001, 4'b1111};
  int cyc;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .NREQ(N), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .alu_ctrl(alu_ctrl), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  function automatic logic [W+3:0] alu_fn(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (c)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a << b[4:0];
      4'b0011: r = b == 0 ? '1 : a / b;
      4'b1000: r = b;
      default: r = a ^ ~b;
    endcase
    return {r == 0, r[W-1], ^r, c[0], r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_ctrl, alu_op1, alu_op2);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_from(input int s, input int e);
    for (int x = s; x <= e && x < NC + 16; x++) begin
      e_ctrl[x] = 4'b1000;
      e_o1[x] = '0;
      e_o2[x] = '0;
      e_rv[x] = '0;
      e_res[x] = '0;
      e_fl[x] = '0;
      e_rst[x] = 1'b0;
    end
  endtask

  initial begin
    logic [N-1:0] er;
    logic [W+3:0] rf;
    bit r, mid, did_mid;
    int ptr, nxt, rate, j, lat;
    mid = 0;
    did_mid = 0;
    ptr = 0;
    nxt = 0;
    rst = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    clear_from(0, NC + 15);
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      cyc = c;
      if (c > 0) begin
        if (e_rst[c]) begin
          chk("rst_alu_ctrl", alu_ctrl, 4'b0000);
          chk("rst_alu_op1", alu_op1, 0);
          chk("rst_alu_op2", alu_op2, 0);
          chk("rst_rsp_valid", rsp_valid, 0);
          chk("rst_rsp_result", rsp_result, 0);
          chk("rst_rsp_flags", rsp_flags, 0);
        end else begin
          chk("alu_ctrl", alu_ctrl, e_ctrl[c]);
          chk("alu_op1", alu_op1, e_o1[c]);
          chk("alu_op2", alu_op2, e_o2[c]);
          chk("rsp_valid", rsp_valid, e_rv[c]);
          if (e_rv[c] != 0) begin
            chk("rsp_result", rsp_result, e_res[c]);
            chk("rsp_flags", rsp_flags, e_fl[c]);
          end
        end
      end
      rate = c < 10 ? 0 : c < 200 ? 100 : 40;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < rate) begin
          pend[i] = 1;
          p_op[i] = ops[$urandom_range(0, 7)];
          p_a[i] = $urandom_range(0, 3) == 0 ? 32'd7 : $urandom;
          p_b[i] = p_op[i] == 4'b0010 ? W'($urandom_range(0, 31)) :
                   $urandom_range(0, 3) == 0 ? W'($urandom_range(0, 9)) : $urandom;
        end
        req_valid[i] = pend[i];
        req_op[4*i +: 4] = p_op[i];
        req_a[W*i +: W] = p_a[i];
        req_b[W*i +: W] = p_b[i];
      end
      r = c < 2 || mid || (c >= 200 && $urandom_range(0, 79) == 0);
      mid = 0;
      rst = r;
      #1;
      er = '0;
      if (!r && c >= nxt) begin
        j = -1;
        for (int k = 0; k < N; k++) if (j < 0 && pend[(ptr + k) % N]) j = (ptr + k) % N;
        if (j >= 0) begin
          er[j] = 1'b1;
          lat = p_op[j] == 4'b0011 ? DIV_LAT : 2;
          for (int e = c + 1; e < c + lat; e++) begin
            e_ctrl[e] = p_op[j];
            e_o1[e] = p_a[j];
            e_o2[e] = p_b[j];
          end
          rf = alu_fn(p_op[j], p_a[j], p_b[j]);
          e_rv[c+lat] = er;
          e_res[c+lat] = rf[W-1:0];
          e_fl[c+lat] = rf[W+3:W];
          nxt = c + lat;
          ptr = (j + 1) % N;
          pend[j] = 0;
          if (c >= 300 && !did_mid) begin
            mid = 1;
            did_mid = 1;
          end
        end
      end
      chk("req_ready", req_ready, er);
      if (r) begin
        clear_from(c + 1, c + DC + 3);
        e_rst[c+1] = 1'b1;
        ptr = 0;
        nxt = c + 1;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
